// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: address-width
// derivation, zero-register index and the storage reset value.
package regfile_pkg;

   localparam int  ZERO_IDX  = 0;
   localparam logic RESET_BIT = 1'b0;

   // clog2 with a floor of one bit so DEPTH=2 still gets a usable address
   function automatic int addr_width(input int depth);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) < depth) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_param_register_en.sv
// Single WIDTH-bit storage register with load enable and async active-low reset.
module register_en
   import regfile_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // storage with load enable; clears asynchronously while reset is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= {WIDTH{RESET_BIT}};
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Register file: DEPTH x WIDTH, two combinational read ports, one write port.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_param
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int ZERO_REG = 1,
   localparam int ADDR_W   = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b
);

   localparam int FIRST = (ZERO_REG != 0) ? ZERO_IDX + 1 : ZERO_IDX;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] stored_a;
   logic [WIDTH-1:0] stored_b;

   // Out-of-range write addresses never match any entry, so they are dropped.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (i < FIRST) begin : g_zero
         assign regs[i] = {WIDTH{RESET_BIT}};
      end else begin : g_store
         logic load;
         assign load = we && (waddr == ADDR_W'(i));
         register_en #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (load),
            .d     (wdata),
            .q     (regs[i])
         );
      end
   end

   // read muxes; unmatched (out-of-range) addresses read as zero
   always_comb begin
      stored_a = {WIDTH{RESET_BIT}};
      stored_b = {WIDTH{RESET_BIT}};
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr_a == ADDR_W'(i)) begin
            stored_a = regs[i];
         end else begin
            stored_a = stored_a;
         end
         if (raddr_b == ADDR_W'(i)) begin
            stored_b = regs[i];
         end else begin
            stored_b = stored_b;
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_valid;

   // write targets a real storage entry (in range, not the zero register)
   always_comb begin
      wr_valid = 1'b0;
      for (int i = FIRST; i < DEPTH; i++) begin
         if (waddr == ADDR_W'(i)) begin
            wr_valid = 1'b1;
         end else begin
            wr_valid = wr_valid;
         end
      end
   end

   // forward the pending write to a matching read port, never during reset
   always_comb begin
      rdata_a = stored_a;
      rdata_b = stored_b;
      if (reset && we && wr_valid) begin
         if (raddr_a == waddr) begin
            rdata_a = wdata;
         end else begin
            rdata_a = stored_a;
         end
         if (raddr_b == waddr) begin
            rdata_b = wdata;
         end else begin
            rdata_b = stored_b;
         end
      end else begin
         rdata_a = stored_a;
         rdata_b = stored_b;
      end
   end
`else
   // no bypass: reads show committed array contents only
   always_comb begin
      rdata_a = stored_a;
      rdata_b = stored_b;
   end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three configurations (32x32 zero-reg, 32x32 plain,
// 24x16 zero-reg) share stimulus and are checked against an array model.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = 5'd0;
   logic [4:0]  raddr_a = 5'd0;
   logic [4:0]  raddr_b = 5'd0;
   logic [31:0] wdata = 32'd0;

   wire [31:0] rda0, rdb0, rda1, rdb1;
   wire [15:0] rda2, rdb2;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [3][32];
   int depth_of [3] = '{32, 32, 24};
   bit zero_of  [3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut0 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda0), .rdata_b(rdb0));

   regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut1 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda1), .rdata_b(rdb1));

   regfile_param #(.WIDTH(16), .DEPTH(24), .ZERO_REG(1)) dut2 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda2), .rdata_b(rdb2));

   // reference storage: a write lands only in a real, in-range entry
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++)
            for (int a = 0; a < 32; a++)
               mem[k][a] <= 32'd0;
      end else if (we) begin
         for (int k = 0; k < 3; k++)
            if (int'(waddr) < depth_of[k] && !(zero_of[k] && waddr == 5'd0))
               mem[k][waddr] <= (k == 2) ? {16'h0000, wdata[15:0]} : wdata;
      end
   end

   function automatic logic [31:0] expect_rd(input int k, input logic [4:0] addr);
      logic real_entry;
      real_entry = (int'(addr) < depth_of[k]) && !(zero_of[k] && addr == 5'd0);
      if (!reset || !real_entry) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (we && waddr == addr) return (k == 2) ? {16'h0000, wdata[15:0]} : wdata;
`endif
      return mem[k][addr];
   endfunction

   function automatic logic [31:0] obs(input int k, input bit port_b);
      case (k)
         0:       return port_b ? rdb0 : rda0;
         1:       return port_b ? rdb1 : rda1;
         default: return port_b ? {16'h0000, rdb2} : {16'h0000, rda2};
      endcase
   endfunction

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd5; raddr_b = 5'd5;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k, 0) !== 32'd0 || obs(k, 1) !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold dut%0d: got a=%h b=%h want 0", k, obs(k, 0), obs(k, 1));
         end
      end
      @(negedge clk);
      we = 1'b0; reset = 1'b1;
      #1;
      checks++;
      if (rda0 !== 32'd0) begin
         errors++;
         $display("FAIL reset_release: got %h want 00000000", rda0);
      end
      do_write(5'd5, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k, 0) !== expect_rd(k, 5'd5)) begin
            errors++;
            $display("FAIL first_write dut%0d: got %h want %h", k, obs(k, 0), expect_rd(k, 5'd5));
         end
      end
      checks++;
      if (rda0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL first_write_const: got %h want deadbeef", rda0);
      end
   endtask

   task automatic test_basic();
      do_write(5'd3, 32'h11111111);
      do_write(5'd7, 32'h22222222);
      raddr_a = 5'd3; raddr_b = 5'd7;
      #1;
      checks++;
      if (rda0 !== 32'h11111111 || rdb0 !== 32'h22222222) begin
         errors++;
         $display("FAIL dual_read: got a=%h b=%h want 11111111 22222222", rda0, rdb0);
      end
      raddr_a = 5'd7;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k, 0) !== expect_rd(k, 5'd7) || obs(k, 1) !== expect_rd(k, 5'd7)) begin
            errors++;
            $display("FAIL same_addr dut%0d: got a=%h b=%h want %h", k, obs(k, 0), obs(k, 1), expect_rd(k, 5'd7));
         end
      end
   endtask

   task automatic test_zero_reg();
      do_write(5'd0, 32'hFFFFFFFF);
      raddr_a = 5'd0; raddr_b = 5'd0;
      #1;
      checks++;
      if (rda0 !== 32'd0 || rda2 !== 16'd0) begin
         errors++;
         $display("FAIL zero_reg: got %h/%h want 0", rda0, rda2);
      end
      checks++;
      if (rda1 !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL plain_r0: got %h want ffffffff", rda1);
      end
   endtask

   task automatic test_we_gating();
      do_write(5'd4, 32'h00000001);
      @(negedge clk);
      we = 1'b0; waddr = 5'd4; wdata = 32'hABCD0000; raddr_a = 5'd4;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k, 0) !== 32'h00000001) begin
            errors++;
            $display("FAIL we_gating dut%0d: got %h want 00000001", k, obs(k, 0));
         end
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] pre;
      do_write(5'd9, 32'h5);
      @(negedge clk);
      we = 1'b1; waddr = 5'd9; wdata = 32'hA; raddr_a = 5'd9;
      #1;
`ifdef REGFILE_BYPASS_EN
      pre = 32'hA;
`else
      pre = 32'h5;
`endif
      checks++;
      if (rda0 !== pre || rda1 !== pre || rda2 !== pre[15:0]) begin
         errors++;
         $display("FAIL pre_edge_rw: got %h/%h/%h want %h", rda0, rda1, rda2, pre);
      end
      @(posedge clk);
      #1 we = 1'b0;
      #1;
      checks++;
      if (rda0 !== 32'hA || rda1 !== 32'hA || rda2 !== 16'hA) begin
         errors++;
         $display("FAIL post_edge_rw: got %h/%h/%h want 0000000a", rda0, rda1, rda2);
      end
   endtask

   task automatic test_npot();
      do_write(5'd30, 32'h1234);
      raddr_a = 5'd30;
      #1;
      checks++;
      if (rda2 !== 16'h0000) begin
         errors++;
         $display("FAIL oob_read: got %h want 0000", rda2);
      end
      do_write(5'd23, 32'h1234);
      raddr_a = 5'd23; raddr_b = 5'd30;
      #1;
      checks++;
      if (rda2 !== 16'h1234) begin
         errors++;
         $display("FAIL top_entry: got %h want 1234", rda2);
      end
      checks++;
      if (rdb0 !== 32'h1234) begin
         errors++;
         $display("FAIL pot_addr30: got %h want 00001234", rdb0);
      end
      @(posedge clk);
      #2 we = 1'b1; reset = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k, 0) !== 32'd0 || obs(k, 1) !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset dut%0d: got a=%h b=%h want 0", k, obs(k, 0), obs(k, 1));
         end
      end
      @(negedge clk);
      we = 1'b0; reset = 1'b1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         we = 1'($urandom_range(0, 1));
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr_b = 5'($urandom_range(0, 31));
         #1;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k, 0) !== expect_rd(k, raddr_a) || obs(k, 1) !== expect_rd(k, raddr_b)) begin
               errors++;
               $display("FAIL random dut%0d it%0d: got a=%h b=%h want %h %h", k, n,
                        obs(k, 0), obs(k, 1), expect_rd(k, raddr_a), expect_rd(k, raddr_b));
            end
         end
      end
      @(negedge clk);
      we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_reg();
      test_we_gating();
      test_same_cycle();
      test_npot();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: DEPTH registers of WIDTH bits with two combinational read ports and one clocked write port with write enable. It generalises the fixed 32-bit always-load register into the architectural register array of the datapath. It sits between instruction decode, which supplies the read addresses, and writeback, which supplies the write port. Register 0 is optionally hardwired to zero, MIPS-style.

## Interface
Parameters:
- WIDTH, 32, data width of each register in bits (≥1)
- DEPTH, 32, number of registers (2..256; need not be a power of two)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage

Ports (ADDR_W = clog2(DEPTH)):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- we  input  1  write enable, sampled on rising clk edge
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr_a  input  ADDR_W  read port A address
- raddr_b  input  ADDR_W  read port B address
- rdata_a  output  WIDTH  read port A data
- rdata_b  output  WIDTH  read port B data

## Operation
- Storage: DEPTH independent WIDTH-bit registers, each with a load enable.
- Write: on rising clk with reset=1 and we=1, register[waddr] <= wdata. All other registers hold. With we=0, all registers hold.
- Zero register: with ZERO_REG=1, writes to address 0 are discarded and rdata_x for address 0 is constant 0. No storage is inferred for entry 0.
- Read: rdata_x = register[raddr_x], combinational. Both ports may address the same register.
- Out-of-range address (≥ DEPTH): reads return 0 and writes are ignored. This applies only when DEPTH is not a power of two.
- Reset: reset=0 clears every register to 0 asynchronously. Both read outputs become 0 without waiting for a clock edge and stay 0 while reset is held, regardless of we.
- Reset mid-operation: a write coinciding with reset assertion or deassertion is lost. The first write is accepted on the first rising edge with reset=1.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N, within the same cycle.
- Read latency: 0 cycles (combinational from address and array state).
- Same-cycle read-of-write address: behaviour is governed by the configuration macro (see Configuration).
- Write-port inputs (we, waddr, wdata) must be stable around the clk edge. The read path has no clock dependency.
- Reset values: rdata_a = 0, rdata_b = 0, all entries = 0.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read bypass. When we=1, waddr == raddr_x, the address is in range, and the address is not the zero register (when ZERO_REG=1), rdata_x = wdata combinationally in the same cycle. This serves single-cycle writeback/decode overlap without an external forwarding mux.
- Undefined: no bypass. rdata_x shows the pre-write stored value until the clk edge commits the write.
- The bypass is always suppressed while reset=0.

## Structure
- Package regfile_pkg:
  - ADDR_W derivation function (clog2)
  - localparam for the zero-register index
  - reset-value constant (all zeros)
- Sub-module register_en: one WIDTH-parametrised register with clk, reset (async active-low), en, d, q. It is instantiated in a generate loop for entries ZERO_REG..DEPTH-1.
- Top level contains:
  - the write-address decoder (one-hot en per entry, gated by we and range check)
  - the two read muxes
  - the optional bypass muxes

## Test plan
- Reset: drive reset=0 with we=1, waddr=5, wdata=32'hDEADBEEF, then release and read addr 5 -> rdata_a = 0. Then write on the next edge -> 32'hDEADBEEF.
- Basic write/dual read: write 32'h11111111 to r3 and 32'h22222222 to r7. Set raddr_a=3, raddr_b=7 -> 32'h11111111 and 32'h22222222. Set raddr_a=raddr_b=7 -> both 32'h22222222.
- Zero register (ZERO_REG=1): write 32'hFFFFFFFF to r0 -> rdata_a(0) = 0. With ZERO_REG=0, the same stimulus -> 32'hFFFFFFFF.
- we gating: we=0, waddr=4, wdata=32'hABCD0000 over 3 edges -> r4 keeps its previous value of 32'h00000001.
- Same-cycle read/write: r9=32'h5, then we=1, waddr=9, wdata=32'hA, raddr_a=9 before the edge -> 32'hA with REGFILE_BYPASS_EN, 32'h5 without. After the edge -> 32'hA in both builds.
- Non-power-of-two depth (DEPTH=24, WIDTH=16): write 16'h1234 to addr 30 -> ignored, and rdata_a(30) = 0. Write to addr 23 -> 16'h1234 readable. Assert reset mid-cycle -> both outputs 0 immediately.
